counter_mod_n: RTL and testbench

Parametrised modulo-N up/down counter for the clock datapath: the generalised successor of the fixed modulo-24 hours counter, used for hours (MOD=24), minutes/seconds (MOD=60) and date fields. It adds a cascade enable, a synchronous parallel load with clamping, and terminal-count flags. It also offers an optional compiled-in auto-repeat front end so held set-buttons step the count at a controlled rate. Counters chain through o_carryup/o_borrowdown into the next stage's i_en.

---
 rtl/counter_pkg.sv | 21 ++
 rtl/counter_autorepeat.sv | 78 +++++++
 rtl/counter_mod_n.sv | 108 ++++++++++
 tb/tb_counter_mod_n.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_autorepeat.sv
// Held-button auto-repeat front end: first step on press, then after REP_DELAY
// enabled ticks, then every REP_PERIOD enabled ticks. Emits a combinational step strobe.
module counter_autorepeat
    import counter_pkg::*;
#(
    parameter int unsigned REP_DELAY  = 500,
    parameter int unsigned REP_PERIOD = 100
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    input  logic i_up,
    input  logic i_down,
    input  logic i_load,
    output logic o_step_c,
    output dir_e o_dir_c
);

    localparam int unsigned TMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned TW   = cnt_width(TMAX + 1);

    rep_state_e      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    dir_e            dir_q, dir_d;
    dir_e            req_dir;

    // Exactly one request held; both or neither counts as released.
    always_comb begin
        req_dir = DIR_NONE;
        if (i_up && !i_down) begin
            req_dir = DIR_UP;
        end else if (i_down && !i_up) begin
            req_dir = DIR_DOWN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            timer_q <= '0;
            dir_q   <= DIR_NONE;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
        end
    end

    // Timer reaching one on an enabled tick means this tick is the step.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dir_d    = dir_q;
        o_step_c = 1'b0;
        o_dir_c  = DIR_NONE;
        if (i_load || req_dir == DIR_NONE) begin
            state_d = IDLE;
            timer_d = '0;
            dir_d   = DIR_NONE;
        end else if (i_en) begin
            if (state_q == IDLE || req_dir != dir_q) begin
                o_step_c = 1'b1;
                o_dir_c  = req_dir;
                state_d  = DELAY;
                timer_d  = TW'(REP_DELAY);
                dir_d    = req_dir;
            end else if (timer_q <= TW'(1)) begin
                o_step_c = 1'b1;
                o_dir_c  = req_dir;
                state_d  = REPEAT;
                timer_d  = TW'(REP_PERIOD);
            end else begin
                timer_d  = timer_q - TW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with cascade enable, clamped load and wrap pulses.
// Define COUNTER_MOD_N_AUTOREPEAT_EN to drive steps from the held-button auto-repeat FSM.
module counter_mod_n
    import counter_pkg::*;
#(
    parameter  int unsigned MOD        = 24,
    parameter  int unsigned RST_VAL    = 0,
    parameter  int unsigned REP_DELAY  = 500,
    parameter  int unsigned REP_PERIOD = 100,
    localparam int unsigned W          = cnt_width(MOD)
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_en,
    input  logic         i_up,
    input  logic         i_down,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_carryup,
    output logic         o_borrowdown,
    output logic         o_at_max,
    output logic         o_at_zero
);

    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);
    localparam logic [W-1:0] RST_CNT = W'(RST_VAL);
    localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);

    if (MOD < 2 || RST_VAL >= MOD || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_err
        $error("counter_mod_n: illegal parameter set");
    end

    logic         step;
    dir_e         step_dir;
    logic [W-1:0] cnt_d;
    logic         carry_d;
    logic         borrow_d;

`ifdef COUNTER_MOD_N_AUTOREPEAT_EN
    counter_autorepeat #(
        .REP_DELAY  (REP_DELAY),
        .REP_PERIOD (REP_PERIOD)
    ) u_autorepeat (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_en     (i_en),
        .i_up     (i_up),
        .i_down   (i_down),
        .i_load   (i_load),
        .o_step_c (step),
        .o_dir_c  (step_dir)
    );
`else
    // Level mode: one step per enabled cycle with exactly one request.
    always_comb begin
        step     = i_en & (i_up ^ i_down);
        step_dir = i_up ? DIR_UP : DIR_DOWN;
    end
`endif

    always_comb begin
        cnt_d    = o_count;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (i_load) begin
            cnt_d = ({1'b0, i_load_val} >= MOD_EXT) ? MAX_VAL : i_load_val;
        end else if (step) begin
            case (step_dir)
                DIR_UP: begin
                    if (o_count == MAX_VAL) begin
                        cnt_d   = '0;
                        carry_d = 1'b1;
                    end else begin
                        cnt_d = o_count + W'(1);
                    end
                end
                DIR_DOWN: begin
                    if (o_count == '0) begin
                        cnt_d    = MAX_VAL;
                        borrow_d = 1'b1;
                    end else begin
                        cnt_d = o_count - W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Flags are registered from the next count so they track o_count exactly.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_count      <= RST_CNT;
            o_carryup    <= 1'b0;
            o_borrowdown <= 1'b0;
            o_at_max     <= (RST_CNT == MAX_VAL);
            o_at_zero    <= (RST_CNT == '0);
        end else begin
            o_count      <= cnt_d;
            o_carryup    <= carry_d;
            o_borrowdown <= borrow_d;
            o_at_max     <= (cnt_d == MAX_VAL);
            o_at_zero    <= (cnt_d == '0);
        end
    end

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed self-checking bench for counter_mod_n (level and auto-repeat builds).
module tb_counter_mod_n;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Hours-style counter (modulus 24) with short repeat timing
    logic       en, up, down, load;
    logic [4:0] load_val, cnt;
    logic       carry, borrow, at_max, at_zero;

    // Minutes-style counter (modulus 60) for load tests
    logic       m_en, m_up, m_load;
    logic [5:0] m_load_val, m_cnt;
    logic       m_carry, m_borrow, m_at_max, m_at_zero;

    // Cascade: seconds-style lower (60) feeding hours-style upper (24)
    logic       lo_en, lo_up, lo_load, hi_load;
    logic [5:0] lo_load_val, lo_cnt;
    logic [4:0] hi_load_val, hi_cnt;
    logic       lo_carry, lo_borrow, lo_at_max, lo_at_zero;
    logic       hi_carry, hi_borrow, hi_at_max, hi_at_zero;

    counter_mod_n #(.MOD(24), .RST_VAL(0), .REP_DELAY(4), .REP_PERIOD(2)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_up(up), .i_down(down),
        .i_load(load), .i_load_val(load_val), .o_count(cnt), .o_carryup(carry),
        .o_borrowdown(borrow), .o_at_max(at_max), .o_at_zero(at_zero)
    );

    counter_mod_n #(.MOD(60)) u_m60 (
        .i_clk(clk), .i_rstn(rstn), .i_en(m_en), .i_up(m_up), .i_down(1'b0),
        .i_load(m_load), .i_load_val(m_load_val), .o_count(m_cnt), .o_carryup(m_carry),
        .o_borrowdown(m_borrow), .o_at_max(m_at_max), .o_at_zero(m_at_zero)
    );

    counter_mod_n #(.MOD(60)) u_lo (
        .i_clk(clk), .i_rstn(rstn), .i_en(lo_en), .i_up(lo_up), .i_down(1'b0),
        .i_load(lo_load), .i_load_val(lo_load_val), .o_count(lo_cnt), .o_carryup(lo_carry),
        .o_borrowdown(lo_borrow), .o_at_max(lo_at_max), .o_at_zero(lo_at_zero)
    );

    counter_mod_n #(.MOD(24)) u_hi (
        .i_clk(clk), .i_rstn(rstn), .i_en(lo_carry), .i_up(1'b1), .i_down(1'b0),
        .i_load(hi_load), .i_load_val(hi_load_val), .o_count(hi_cnt), .o_carryup(hi_carry),
        .o_borrowdown(hi_borrow), .o_at_max(hi_at_max), .o_at_zero(hi_at_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b1;
        en = 0; up = 0; down = 0; load = 0; load_val = '0;
        m_en = 0; m_up = 0; m_load = 0; m_load_val = '0;
        lo_en = 0; lo_up = 0; lo_load = 0; hi_load = 0; lo_load_val = '0; hi_load_val = '0;
        #2 rstn = 1'b0;
        #2;
        check("rst_count", 32'(cnt), 0);
        check("rst_carry", 32'(carry), 0);
        check("rst_borrow", 32'(borrow), 0);
        check("rst_at_zero", 32'(at_zero), 1);
        check("rst_at_max", 32'(at_max), 0);
        @(negedge clk) rstn = 1'b1;

`ifndef COUNTER_MOD_N_AUTOREPEAT_EN
        // Full wrap: 1..23 then back to 0 with carry
        en = 1; up = 1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            check("wrap_count", 32'(cnt), 32'(i % 24));
            check("wrap_carry", 32'(carry), (i == 24) ? 1 : 0);
            check("wrap_at_max", 32'(at_max), ((i % 24) == 23) ? 1 : 0);
        end
        up = 0; down = 1;
        tick();
        check("down_wrap_count", 32'(cnt), 23);
        check("down_wrap_borrow", 32'(borrow), 1);
        down = 0;
        tick();
        check("borrow_one_cycle", 32'(borrow), 0);
        check("idle_hold", 32'(cnt), 23);
        up = 1; down = 1;
        tick();
        check("both_hold", 32'(cnt), 23);
        check("both_no_carry", 32'(carry), 0);
        check("both_no_borrow", 32'(borrow), 0);
        down = 0; en = 0;
        tick();
        check("en_low_hold", 32'(cnt), 23);
        en = 1;
        tick();
        check("up_wrap_count", 32'(cnt), 0);
        check("up_wrap_carry", 32'(carry), 1);
        up = 0;
`else
        // Held up: steps on ticks 0,4,6,8,10
        en = 1; up = 1;
        for (int k = 0; k < 12; k++) begin
            int exp_c;
            exp_c = (k >= 10) ? 5 : (k >= 8) ? 4 : (k >= 6) ? 3 : (k >= 4) ? 2 : 1;
            tick();
            check("rep_count", 32'(cnt), 32'(exp_c));
        end
        up = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rep_release_hold", 32'(cnt), 5);
        end
        up = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rep_second_press", 32'(cnt), (k >= 4) ? 7 : 6);
        end
        #2 rstn = 1'b0;
        #1;
        check("rep_rst_count", 32'(cnt), 0);
        check("rep_rst_carry", 32'(carry), 0);
        check("rep_rst_at_zero", 32'(at_zero), 1);
        @(negedge clk) rstn = 1'b1;
        tick();
        check("rep_new_press", 32'(cnt), 1);
        tick();
        check("rep_new_press_hold", 32'(cnt), 1);
        up = 0;
`endif
        en = 0; up = 0; down = 0;

        // Load and clamp on MOD=60
        m_load = 1; m_load_val = 6'd45;
        tick();
        check("load_45", 32'(m_cnt), 45);
        m_load_val = 6'd63;
        tick();
        check("load_clamp", 32'(m_cnt), 59);
        check("load_clamp_at_max", 32'(m_at_max), 1);
        m_en = 1; m_up = 1; m_load_val = 6'd10;
        tick();
        check("load_beats_step", 32'(m_cnt), 10);
        check("load_no_carry", 32'(m_carry), 0);
        m_load = 0;
        tick();
        check("step_after_load", 32'(m_cnt), 11);
        m_up = 0;

        // Cascade 59:23 -> 0:0
        lo_load = 1; lo_load_val = 6'd59; hi_load = 1; hi_load_val = 5'd23;
        tick();
        check("casc_lo_loaded", 32'(lo_cnt), 59);
        check("casc_hi_loaded", 32'(hi_cnt), 23);
        lo_load = 0; hi_load = 0; lo_en = 1; lo_up = 1;
        tick();
        check("casc_lo_wrap", 32'(lo_cnt), 0);
        check("casc_lo_carry", 32'(lo_carry), 1);
        check("casc_hi_wait", 32'(hi_cnt), 23);
        lo_up = 0;
        tick();
        check("casc_hi_wrap", 32'(hi_cnt), 0);
        check("casc_hi_carry", 32'(hi_carry), 1);
        check("casc_lo_carry_drop", 32'(lo_carry), 0);
        tick();
        check("casc_hi_carry_drop", 32'(hi_carry), 0);
        lo_en = 0;

        // Async reset mid-count
        m_up = 1;
        tick();
        check("pre_rst_count", 32'(m_cnt), 12);
        m_up = 0;
        #2 rstn = 1'b0;
        #1;
        check("async_rst_m60", 32'(m_cnt), 0);
        check("async_rst_zero_flag", 32'(m_at_zero), 1);
        @(negedge clk) rstn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
